id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage. Captures the decoded instruction (control bundle, register operands, immediate, PC) into the ID/EX register. Detects load-use hazards against the instruction already in EX, inserts one bubble per hazard and holds the decode/fetch side. Honours downstream stall and pipeline flush, and keeps a saturating count of inserted bubbles.

## Interface
Parameters:
- XLEN, 32, data/PC/immediate width
- REG_AW, 5, register index width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1/rs2 (rs2: R-type, store)
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  extended immediate
- id_dm_we, id_rf_we, id_result_src, id_alu_src  in  1  decoded controls
- id_alu_control  in  3  ALU op (ADD 000, SUB 001, AND 010, OR 011, SLT 100, XOR 101, SLL 110, SRL 111)
- ex_stall  in  1  downstream cannot accept; hold EX contents
- flush  in  1  kill the instruction in ID and in EX
- id_ready  out  1  ID instruction accepted this cycle; upstream advances only when high
- hazard_stall  out  1  load-use hazard detected this cycle
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_dm_we, ex_rf_we, ex_result_src, ex_alu_src, ex_alu_control  out  matching widths  registered ID/EX contents
- bubble_count  out  CNT_W  saturating count of hazard bubbles

## Operation
- Register state: EMPTY (ex_valid=0) or FULL (ex_valid=1). Every ex_* output comes directly from a flop.
- hazard_stall = id_valid & ex_valid & ex_result_src & ex_rf_we & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)). It is combinational.
- id_ready = ~ex_stall & ~hazard_stall & ~flush.
- Next-state priority on each clock edge, when rst_n=1:
  1. flush: load a bubble.
  2. ex_stall: hold all ex_* unchanged.
  3. hazard_stall: load a bubble.
  4. Otherwise: capture all id_* fields, with ex_valid <= id_valid.
- Bubble: ex_valid=0. All controls are 0 (dm_we=0, rf_we=0; no side effects). All data/index fields are 0.
- When id_valid=0 and no stall/flush, the captured fields are still loaded as-is. Controls are gated: ex_dm_we and ex_rf_we <= id_* & id_valid.
- bubble_count increments by 1 on each edge where priority 3 fires. It saturates at 2^CNT_W-1 and does not increment on flush or ex_stall.
- Reset, synchronous with rst_n=0 at the edge: all ex_* outputs 0, ex_valid=0, bubble_count=0. A reset asserted mid-stall discards the held instruction.

## Timing
- Latency: ID to EX is 1 cycle. An instruction presented with id_ready=1 appears on ex_* after the next edge.
- hazard_stall and id_ready are valid in the same cycle as their inputs; no registered lag.
- A load followed by a dependent instruction gives exactly one bubble. In the next cycle the load has moved out of EX, hazard_stall drops, and the dependent instruction is captured.
- ex_stall held for N cycles means ex_* is constant for N edges. hazard_stall may be high during ex_stall; it does not count a bubble and does not overwrite EX.
- flush together with ex_stall: flush wins and EX becomes a bubble.
- flush together with hazard_stall: a single bubble, not counted.
- bubble_count at max plus another hazard: the count stays at max.

## Structure
- Shared package pipe_pkg holds:
  - ALU control encodings (ALU_ADD..ALU_SRL, 3-bit)
  - opcode constants (LOAD, STORE, OP, OP_IMM)
  - packed struct ctrl_t {dm_we, rf_we, result_src, alu_src, alu_control[2:0]}
  - XLEN / REG_AW defaults
- One sub-module: load_use_detect, purely combinational. It takes the ID source indices/uses and the EX rd/valid/result_src/rf_we, and produces hazard_stall.
- Top level contains the ID/EX flops, the priority mux and the bubble counter.

## Test plan
- Reset: hold rst_n=0 for 2 edges with id_valid=1 -> all ex_*=0, ex_valid=0, bubble_count=0. Release -> the next edge captures the ID fields.
- Load-use: LW x5 (result_src=1, rf_we=1, rd=5) then ADD x6,x5,x7 (uses_rs1, rs1=5) -> hazard_stall=1 and id_ready=0 for one cycle, one bubble in EX, ADD captured on the following edge, bubble_count=1.
- No false hazard: LW to x0, then an instruction reading x0 -> hazard_stall=0. ADDI x5 then ADD reading x5 -> hazard_stall=0. SW with uses_rs2=0 mismatch -> no stall.
- Downstream stall: capture SUB (alu_control=001), then ex_stall=1 for 3 cycles with a new ID instruction presented -> ex_* constant, id_ready=0. Drop ex_stall -> the new instruction is captured.
- Flush priority: flush=1 together with ex_stall=1 and a pending hazard -> EX becomes a bubble (ex_valid=0, ex_dm_we=0), bubble_count unchanged.
- Counter saturation: CNT_W=2, force 5 load-use hazards -> bubble_count reaches 3 and stays at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline encodings, control bundle and width defaults
package pipe_pkg;
   localparam int XLEN_D   = 32;
   localparam int REG_AW_D = 5;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;
   localparam logic [6:0] LOAD    = 7'b0000011;
   localparam logic [6:0] STORE   = 7'b0100011;
   localparam logic [6:0] OP      = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   typedef struct packed {
      logic       dm_we;
      logic       rf_we;
      logic       result_src;
      logic       alu_src;
      logic [2:0] alu_control;
   } ctrl_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load in EX
module load_use_detect import pipe_pkg::*; #(
   parameter int REG_AW = REG_AW_D
) (
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              ex_valid,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_result_src,
   input  logic              ex_rf_we,
   output logic              hazard_stall
);
   assign hazard_stall = id_valid & ex_valid & ex_result_src & ex_rf_we & (ex_rd != '0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and bubble counter
module id_ex_stage import pipe_pkg::*; #(
   parameter int XLEN   = XLEN_D,
   parameter int REG_AW = REG_AW_D,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_dm_we,
   input  logic              id_rf_we,
   input  logic              id_result_src,
   input  logic              id_alu_src,
   input  logic [2:0]        id_alu_control,
   input  logic              ex_stall,
   input  logic              flush,
   output logic              id_ready,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic              ex_dm_we,
   output logic              ex_rf_we,
   output logic              ex_result_src,
   output logic              ex_alu_src,
   output logic [2:0]        ex_alu_control,
   output logic [CNT_W-1:0]  bubble_count
);
   ctrl_t ctrl_q;
   logic  bubble;
   load_use_detect #(.REG_AW(REG_AW)) u_detect (
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_valid     (ex_valid),
      .ex_rd        (ex_rd),
      .ex_result_src(ctrl_q.result_src),
      .ex_rf_we     (ctrl_q.rf_we),
      .hazard_stall (hazard_stall)
   );
   assign id_ready       = ~ex_stall & ~hazard_stall & ~flush;
   assign ex_dm_we       = ctrl_q.dm_we;
   assign ex_rf_we       = ctrl_q.rf_we;
   assign ex_result_src  = ctrl_q.result_src;
   assign ex_alu_src     = ctrl_q.alu_src;
   assign ex_alu_control = ctrl_q.alu_control;
   // reset, flush and an unstalled hazard all leave an all-zero bubble in EX
   assign bubble = ~rst_n | flush | (~ex_stall & hazard_stall);
   always_ff @(posedge clk) begin
      if (bubble) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ctrl_q      <= '0;
      end else if (!ex_stall) begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ctrl_q      <= '{dm_we: id_dm_we & id_valid, rf_we: id_rf_we & id_valid,
                          result_src: id_result_src, alu_src: id_alu_src, alu_control: id_alu_control};
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n)
         bubble_count <= '0;
      else if (!flush && !ex_stall && hazard_stall && !(&bubble_count))
         bubble_count <= bubble_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
   logic clk = 1'b0, rst_n;
   logic id_valid, id_uses_rs1, id_uses_rs2, id_dm_we, id_rf_we, id_result_src, id_alu_src;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [2:0] id_alu_control;
   logic ex_stall, flush;
   logic id_ready, hazard_stall, ex_valid, ex_dm_we, ex_rf_we, ex_result_src, ex_alu_src;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [2:0] ex_alu_control;
   logic [15:0] bubble_count;
   logic b_ready, b_hz, b_valid, b_dm, b_rf, b_rs, b_as;
   logic [31:0] b_pc, b_d1, b_d2, b_imm;
   logic [4:0] b_rs1, b_rs2, b_rd;
   logic [2:0] b_alu;
   logic [1:0] b_cnt;
   logic [150:0] dut_bus;
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_dm_we(id_dm_we), .id_rf_we(id_rf_we),
      .id_result_src(id_result_src), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
      .ex_stall(ex_stall), .flush(flush), .id_ready(id_ready), .hazard_stall(hazard_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_dm_we(ex_dm_we),
      .ex_rf_we(ex_rf_we), .ex_result_src(ex_result_src), .ex_alu_src(ex_alu_src),
      .ex_alu_control(ex_alu_control), .bubble_count(bubble_count));

   id_ex_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_dm_we(id_dm_we), .id_rf_we(id_rf_we),
      .id_result_src(id_result_src), .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
      .ex_stall(ex_stall), .flush(flush), .id_ready(b_ready), .hazard_stall(b_hz),
      .ex_valid(b_valid), .ex_pc(b_pc), .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd),
      .ex_rs1_data(b_d1), .ex_rs2_data(b_d2), .ex_imm(b_imm), .ex_dm_we(b_dm),
      .ex_rf_we(b_rf), .ex_result_src(b_rs), .ex_alu_src(b_as),
      .ex_alu_control(b_alu), .bubble_count(b_cnt));

   assign dut_bus = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
                     ex_dm_we, ex_rf_we, ex_result_src, ex_alu_src, ex_alu_control};

   // behavioural model of the EX slot
   logic m_valid, m_dm, m_rf, m_rs, m_as;
   logic [31:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0] m_rs1, m_rs2, m_rd;
   logic [2:0] m_alu;
   int m_cnt, m_cnt2;

   function automatic logic [150:0] m_bus();
      return {m_valid, m_pc, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_dm, m_rf, m_rs, m_as, m_alu};
   endfunction

   function automatic logic m_hazard();
      logic reads_rd;
      reads_rd = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
      return id_valid && m_valid && m_rs && m_rf && m_rd != 0 && reads_rd;
   endfunction

   task automatic m_clear();
      {m_valid, m_pc, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_dm, m_rf, m_rs, m_as, m_alu} = '0;
   endtask

   task automatic tick();
      logic hz;
      hz = m_hazard();
      @(posedge clk);
      if (!rst_n) begin
         m_clear();
         m_cnt = 0;
         m_cnt2 = 0;
      end else if (flush) m_clear();
      else if (ex_stall) begin
      end else if (hz) begin
         m_clear();
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end else begin
         {m_valid, m_pc, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm} =
            {id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm};
         m_dm = id_dm_we & id_valid;
         m_rf = id_rf_we & id_valid;
         {m_rs, m_as, m_alu} = {id_result_src, id_alu_src, id_alu_control};
      end
      #1;
   endtask

   task automatic rand_id();
      id_valid = 1'b1;
      id_pc = $urandom;
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      {id_uses_rs1, id_uses_rs2, id_dm_we, id_rf_we, id_result_src, id_alu_src} = 6'($urandom);
      id_alu_control = 3'($urandom);
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm = $urandom;
   endtask

   task automatic load_x5();
      rand_id();
      {id_rd, id_result_src, id_rf_we, id_dm_we} = {5'd5, 3'b110};
   endtask

   task automatic test_reset();
      logic [31:0] pc;
      rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;
      rand_id();
      tick();
      tick();
      total++;
      if (dut_bus !== '0) $display("FAIL reset_ex: got %h want 0", dut_bus); else passed++;
      total++;
      if (bubble_count !== 16'd0 || b_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d/%0d want 0", bubble_count, b_cnt); else passed++;
      rst_n = 1'b1;
      rand_id();
      pc = id_pc;
      tick();
      total++;
      if (ex_pc !== pc || ex_valid !== 1'b1) $display("FAIL reset_release: pc %h valid %b want %h 1", ex_pc, ex_valid, pc); else passed++;
   endtask

   task automatic test_load_use();
      id_valid = 1'b0;
      tick();
      load_x5();
      tick();
      rand_id();
      {id_rs1, id_uses_rs1, id_rd, id_result_src} = {5'd5, 1'b1, 5'd6, 1'b0};
      #1;
      total++;
      if (hazard_stall !== 1'b1 || id_ready !== 1'b0) $display("FAIL lu_detect: hz %b rdy %b want 1 0", hazard_stall, id_ready); else passed++;
      tick();
      total++;
      if (ex_valid !== 1'b0 || bubble_count !== 16'd1) $display("FAIL lu_bubble: valid %b cnt %0d want 0 1", ex_valid, bubble_count); else passed++;
      total++;
      if (hazard_stall !== 1'b0 || id_ready !== 1'b1) $display("FAIL lu_release: hz %b rdy %b want 0 1", hazard_stall, id_ready); else passed++;
      tick();
      total++;
      if (ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || dut_bus !== m_bus()) $display("FAIL lu_capture: got %h want %h", dut_bus, m_bus()); else passed++;
   endtask

   task automatic test_no_false_hazard();
      rand_id();
      {id_rd, id_result_src, id_rf_we, id_rs1, id_uses_rs1, id_uses_rs2} = {5'd0, 1'b1, 1'b1, 5'd1, 2'b10};
      tick();
      rand_id();
      {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_result_src, id_rf_we} = {10'd0, 2'b11, 5'd5, 2'b01};
      #1;
      total++;
      if (hazard_stall !== 1'b0) $display("FAIL nofh_x0: hz %b want 0", hazard_stall); else passed++;
      tick();
      load_x5();
      {id_rs1, id_uses_rs1, id_uses_rs2} = {5'd5, 2'b10};
      #1;
      total++;
      if (hazard_stall !== 1'b0) $display("FAIL nofh_alu: hz %b want 0", hazard_stall); else passed++;
      tick();
      rand_id();
      {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rf_we, id_dm_we, id_result_src} = {5'd2, 5'd5, 2'b10, 3'b010};
      #1;
      total++;
      if (hazard_stall !== 1'b0) $display("FAIL nofh_store: hz %b want 0", hazard_stall); else passed++;
      tick();
      total++;
      if (dut_bus !== m_bus()) $display("FAIL nofh_capture: got %h want %h", dut_bus, m_bus()); else passed++;
   endtask

   task automatic test_ex_stall();
      logic [150:0] held;
      logic [31:0] pc;
      rand_id();
      {id_alu_control, id_result_src} = {3'b001, 1'b0};
      tick();
      held = m_bus();
      rand_id();
      id_result_src = 1'b0;
      pc = id_pc;
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (id_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, id_ready); else passed++;
         tick();
         total++;
         if (dut_bus !== held || ex_alu_control !== 3'b001) $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_bus, held); else passed++;
      end
      ex_stall = 1'b0;
      tick();
      total++;
      if (ex_pc !== pc || ex_valid !== 1'b1) $display("FAIL stall_release: pc %h want %h", ex_pc, pc); else passed++;
   endtask

   task automatic test_flush();
      int c0;
      load_x5();
      tick();
      rand_id();
      {id_rs1, id_uses_rs1} = {5'd5, 1'b1};
      flush = 1'b1; ex_stall = 1'b1;
      #1;
      total++;
      if (hazard_stall !== 1'b1 || id_ready !== 1'b0) $display("FAIL flush_detect: hz %b rdy %b want 1 0", hazard_stall, id_ready); else passed++;
      c0 = m_cnt;
      tick();
      total++;
      if (dut_bus !== '0 || ex_dm_we !== 1'b0) $display("FAIL flush_bubble: got %h want 0", dut_bus); else passed++;
      total++;
      if (bubble_count !== 16'(c0)) $display("FAIL flush_cnt: got %0d want %0d", bubble_count, c0); else passed++;
      flush = 1'b0; ex_stall = 1'b0;
   endtask

   task automatic test_saturation();
      int hz_seen = 0;
      load_x5();
      {id_rs1, id_uses_rs1, id_uses_rs2} = {5'd5, 2'b10};
      for (int i = 0; i < 10; i++) begin
         if (m_hazard()) hz_seen++;
         tick();
         total++;
         if (b_cnt !== 2'(m_cnt2) || bubble_count !== 16'(m_cnt)) $display("FAIL sat_step[%0d]: got %0d/%0d want %0d/%0d", i, bubble_count, b_cnt, m_cnt, m_cnt2); else passed++;
      end
      total++;
      if (hz_seen != 5 || b_cnt !== 2'd3) $display("FAIL sat_final: hazards %0d cnt %0d want 5 3", hz_seen, b_cnt); else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_id();
         id_valid = ($urandom_range(0, 4) != 0);
         ex_stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         rst_n = ($urandom_range(0, 49) != 0);
         #1;
         total++;
         if (hazard_stall !== m_hazard() || id_ready !== (!ex_stall && !flush && !m_hazard()))
            $display("FAIL rand_comb[%0d]: hz %b rdy %b want %b %b", i, hazard_stall, id_ready, m_hazard(), !ex_stall && !flush && !m_hazard());
         else passed++;
         tick();
         total++;
         if (dut_bus !== m_bus() || bubble_count !== 16'(m_cnt) || b_cnt !== 2'(m_cnt2))
            $display("FAIL rand_ex[%0d]: got %h cnt %0d/%0d want %h cnt %0d/%0d", i, dut_bus, bubble_count, b_cnt, m_bus(), m_cnt, m_cnt2);
         else passed++;
      end
      {rst_n, ex_stall, flush} = 3'b100;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      m_clear();
      m_cnt = 0;
      m_cnt2 = 0;
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_ex_stall();
      test_flush();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
